// File: rtl/addr4u_share_ctrl.sv
// addr4u_share_ctrl
// Time-shares a single external combinational 4-bit adder (5-bit sum) among
// NREQ requesters. A round-robin arbiter picks one valid requester, the
// operands are held on the adder for SETTLE_CYC cycles, and the sum is
// captured and returned with the requester ID.
//
// Optional feature macro: ADDR_RECHECK_EN
//   defined   - every add is re-executed with swapped operands. A mismatch
//               raises rsp_err and bumps the saturating err_cnt.
//   undefined - single execution; rsp_err and err_cnt are tied to 0.
module addr4u_share_ctrl #(
    parameter int NREQ       = 4,
    parameter int SETTLE_CYC = 1,
    localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    output logic [3:0]        add_a,
    output logic [3:0]        add_b,
    input  logic [4:0]        add_sum,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [4:0]        rsp_sum,
    output logic              rsp_err,
    output logic [7:0]        err_cnt,
    output logic              busy
);

    localparam int CNTW = $clog2(SETTLE_CYC + 1);
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(SETTLE_CYC);

`ifdef ADDR_RECHECK_EN
    typedef enum logic [2:0] {IDLE, SETTLE, CAPTURE, SETTLE2, CHECK, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, RESP} state_t;
`endif

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  id_r;
    logic [4:0]      sum_r;
    logic [CNTW-1:0] cnt;

    // Arbiter outputs
    logic            found;
    logic [IDW-1:0]  grant_id;
    logic [3:0]      grant_a;
    logic [3:0]      grant_b;
    logic            hi_found;
    logic [IDW-1:0]  hi_id;
    logic            lo_found;
    logic [IDW-1:0]  lo_id;

    // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid overall
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        hi_found  = 1'b0;
        hi_id     = '0;
        lo_found  = 1'b0;
        lo_id     = '0;
        grant_a   = '0;
        grant_b   = '0;
        req_ready = '0;
        // Scan downwards so the lowest qualifying index is the last one written.
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                lo_found = 1'b1;
                lo_id    = IDW'(j);
                if (IDW'(j) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_id    = IDW'(j);
                end
            end
        end
        found    = hi_found | lo_found;
        grant_id = hi_found ? hi_id : lo_id;
        for (int j = 0; j < NREQ; j++) begin
            if (IDW'(j) == grant_id) begin
                grant_a = req_a[4*j +: 4];
                grant_b = req_b[4*j +: 4];
            end
        end
        if (rst_n && state == IDLE && found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

`ifdef ADDR_RECHECK_EN
    logic       rsp_err_r;
    logic [7:0] err_cnt_r;
`endif

    // Sequencer: accept, settle, capture (and optionally re-check), respond
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous here, so it is only seen on a rising clock edge.
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            id_r   <= '0;
            sum_r  <= '0;
            cnt    <= '0;
            add_a  <= '0;
            add_b  <= '0;
`ifdef ADDR_RECHECK_EN
            rsp_err_r <= 1'b0;
            err_cnt_r <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments make all state update together at the edge, which is what lets the operand swap below read the old values.
            case (state)
                IDLE: begin
                    if (found) begin
                        add_a <= grant_a;
                        add_b <= grant_b;
                        id_r  <= grant_id;
                        cnt   <= CNT_LOAD;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == CNTW'(1)) begin
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    sum_r <= add_sum;
`ifdef ADDR_RECHECK_EN
                    add_a <= add_b;
                    add_b <= add_a;
                    cnt   <= CNT_LOAD;
                    state <= SETTLE2;
`else
                    state <= RESP;
`endif
                end
`ifdef ADDR_RECHECK_EN
                SETTLE2: begin
                    if (cnt == CNTW'(1)) begin
                        state <= CHECK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CHECK: begin
                    rsp_err_r <= (add_sum != sum_r);
                    if (add_sum != sum_r && err_cnt_r != 8'hFF) begin
                        err_cnt_r <= err_cnt_r + 8'd1;
                    end
                    state <= RESP;
                end
`endif
                RESP: begin
                    if (rsp_ready) begin
                        rr_ptr <= (id_r == IDW'(NREQ - 1)) ? '0 : id_r + IDW'(1);
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign rsp_id    = id_r;
    assign rsp_sum   = sum_r;

`ifdef ADDR_RECHECK_EN
    assign rsp_err = rsp_err_r;
    assign err_cnt = err_cnt_r;
`else
    assign rsp_err = 1'b0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_addr4u_share_ctrl.sv
// Testbench for addr4u_share_ctrl. Models the shared adder (with an optional
// fault on the swapped-operand pass) and checks the controller against a
// transaction-level reference: round-robin pointer, a+b, fixed latency.
module tb_addr4u_share_ctrl;

    localparam int N   = 4;
    localparam int S   = 3;
    localparam int IDW = 2;
`ifdef ADDR_RECHECK_EN
    localparam int LAT = 2 * S + 3;
    localparam bit CHK = 1'b1;
`else
    localparam int LAT = S + 2;
    localparam bit CHK = 1'b0;
`endif

    typedef logic [N-1:0]   mask_t;
    typedef logic [4*N-1:0] bus_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    mask_t          req_valid = '0;
    mask_t          req_ready;
    bus_t           req_a = '0;
    bus_t           req_b = '0;
    logic [3:0]     add_a, add_b;
    logic [4:0]     add_sum;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [IDW-1:0] rsp_id;
    logic [4:0]     rsp_sum;
    logic           rsp_err;
    logic [7:0]     err_cnt;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;
    int model_ptr = 0;
    int model_err_cnt = 0;
    bit fault_mode = 1'b0;

    addr4u_share_ctrl #(.NREQ(N), .SETTLE_CYC(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_err(rsp_err),
        .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Shared adder; in fault mode the swapped pass of 1+2 (i.e. 2+1) returns 5'h1F
    assign add_sum = (fault_mode && add_a == 4'd2 && add_b == 4'd1) ? 5'h1F
                                                                     : ({1'b0, add_a} + {1'b0, add_b});

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model_pick(input mask_t mask);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (model_ptr + k) % N;
            if (mask[j]) return j;
        end
        return -1;
    endfunction

    function automatic mask_t onehot(input int i);
        mask_t m;
        m = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_id"},    rsp_id,    0);
        check({tag, "_rsp_sum"},   rsp_sum,   0);
        check({tag, "_rsp_err"},   rsp_err,   0);
        check({tag, "_add_a"},     add_a,     0);
        check({tag, "_add_b"},     add_b,     0);
        check({tag, "_err_cnt"},   err_cnt,   0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        model_ptr = 0;
        model_err_cnt = 0;
    endtask

    // One full transaction: offer mask, check grant, latency, result, stall, release
    task automatic run_txn(input mask_t mask, input bus_t a_bus, input bus_t b_bus, input int stall);
        int win;
        int c;
        logic [3:0] ea, eb;
        logic [4:0] exp_sum;
        bit exp_err;
        bit busy_bad, grant_bad, stall_bad;
        win = model_pick(mask);
        ea = a_bus[4*win +: 4];
        eb = b_bus[4*win +: 4];
        exp_sum = {1'b0, ea} + {1'b0, eb};
        exp_err = CHK && fault_mode && ea == 4'd1 && eb == 4'd2;

        @(negedge clk);
        req_valid = mask;
        req_a = a_bus;
        req_b = b_bus;
        #1;
        check("grant", req_ready, onehot(win));
        @(posedge clk);
        @(negedge clk);
        c = 1;
        check("hold_a", add_a, ea);
        check("hold_b", add_b, eb);
        busy_bad = 1'b0;
        grant_bad = 1'b0;
        while (!rsp_valid && c < 200) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            req_valid = mask_t'($urandom);
            req_a = bus_t'($urandom);
            req_b = bus_t'($urandom);
            #1;
            if (req_ready !== '0) grant_bad = 1'b1;
            @(negedge clk);
            c++;
        end
        check("latency", c, LAT);
        check("busy_during", busy_bad, 0);
        check("no_grant_busy", grant_bad, 0);
        check("rsp_id", rsp_id, win);
        check("rsp_sum", rsp_sum, exp_sum);
        check("rsp_err", rsp_err, exp_err);
        check("add_a_resp", add_a, CHK ? eb : ea);
        if (exp_err && model_err_cnt < 255) model_err_cnt++;
        check("err_cnt", err_cnt, model_err_cnt);

        stall_bad = 1'b0;
        for (int k = 0; k < stall; k++) begin
            req_valid = mask_t'($urandom_range(1, (1 << N) - 1));
            #1;
            if (rsp_valid !== 1'b1 || rsp_id !== IDW'(win) || rsp_sum !== exp_sum ||
                rsp_err !== exp_err || req_ready !== '0 || busy !== 1'b1)
                stall_bad = 1'b1;
            @(negedge clk);
        end
        check("stall_stable", stall_bad, 0);
        req_valid = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_after", {busy, rsp_valid}, 0);
        model_ptr = (win + 1) % N;
    endtask

    initial begin
        bit idle_bad;
        bit ghost_rsp;
        bus_t ab, bb;

        do_reset();

        // No requests: block stays idle and never grants
        idle_bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || req_ready !== '0 || rsp_valid !== 1'b0) idle_bad = 1'b1;
        end
        check("idle_no_req", idle_bad, 0);

        // Single request on requester 2: 9 + 8 = 17
        run_txn(mask_t'(4'b0100), bus_t'(16'h0900), bus_t'(16'h0800), 0);

        // All requesters valid after reset: rotation 0,1,2,3,0; requester 3 does 15+15
        do_reset();
        ab = bus_t'(16'hF735);
        bb = bus_t'(16'hF9A2);
        for (int t = 0; t < 5; t++) run_txn(mask_t'(4'b1111), ab, bb, 0);

        // Long response stall
        run_txn(mask_t'(4'b0011), bus_t'(16'h00C4), bus_t'(16'h0057), 10);

        // Reset pulsed during SETTLE discards the transaction
        @(negedge clk);
        req_valid = mask_t'(4'b0001);
        req_a = bus_t'(16'h0005);
        req_b = bus_t'(16'h0006);
        #1;
        check("grant_pre_reset", req_ready, 4'b0001);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        model_ptr = 0;
        model_err_cnt = 0;
        ghost_rsp = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) ghost_rsp = 1'b1;
        end
        check("no_rsp_after_reset", ghost_rsp, 0);
        run_txn(mask_t'(4'b1001), bus_t'(16'h3001), bus_t'(16'h4002), 0);
        run_txn(mask_t'(4'b1001), bus_t'(16'h3001), bus_t'(16'h4002), 0);

        // Zero operands
        run_txn(mask_t'(4'b0010), bus_t'(16'h0000), bus_t'(16'h0000), 1);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            run_txn(mask_t'($urandom_range(1, (1 << N) - 1)), bus_t'($urandom), bus_t'($urandom),
                    int'($urandom_range(0, 3)));
        end

`ifdef ADDR_RECHECK_EN
        // Faulty swapped pass: sum from the first pass, error flagged, counter saturates
        do_reset();
        fault_mode = 1'b1;
        for (int t = 0; t < 300; t++) begin
            run_txn(mask_t'($urandom_range(1, (1 << N) - 1)), bus_t'(16'h1111), bus_t'(16'h2222), 0);
        end
        check("err_cnt_saturated", err_cnt, 255);
        fault_mode = 1'b0;
        run_txn(mask_t'(4'b0001), bus_t'(16'h0001), bus_t'(16'h0002), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
